// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: grants one requester, drives S1:S0/GNT/VALID.
// Optional forced release after MAX_HOLD cycles when HOLD_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    input  logic       DONE,
    output logic       S0,
    output logic       S1,
    output logic [3:0] GNT,
    output logic       VALID,
    output logic       TMO
);

`ifdef HOLD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;

    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;
    logic             tmo_hit;
    logic             req_drop;
    logic             rel;

    // Round-robin search starting one past the last winner
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign tmo_hit  = TMO_EN && (cnt_q == CNT_TMO);
    assign req_drop = ~REQ[sel_q];
    assign rel      = DONE | req_drop | tmo_hit;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    sel_d   = win;
                    last_d  = win;
                    gnt_d   = 4'b0001 << win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rel) begin
                    // Timeout only reported when nothing else ended the grant
                    tmo_d   = tmo_hit & ~DONE & ~req_drop;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = ST_GAP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            cnt_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign S0    = sel_q[0];
    assign S1    = sel_q[1];
    assign GNT   = gnt_q;
    assign VALID = valid_q;
    assign TMO   = tmo_q;

endmodule
